spi_flash_rd_ctrl: RTL and testbench

- SPI-NOR read master sitting directly upstream of the N25Q-family serial flash (flash model in simulation, real device on board).
- Takes byte-addressed burst read requests from the system side and generates C, S# and DQ0.
- Issues READ (0x03) with a 24-bit address and shifts data in on DQ1.
- Returns bytes on a valid/ready stream, pausing the serial clock under backpressure.

---
 rtl/spi_flash_rd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_rd_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_ctrl.sv
// SPI-NOR burst read master: READ 0x03 + 24-bit address, data bytes returned on a valid/ready stream.
// Define FAST_READ_EN to issue FAST_READ 0x0B with 8 dummy clocks between address and data.
module spi_flash_rd_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8,
    parameter int CS_HIGH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             spi_c,
    output logic             spi_s_n,
    output logic             spi_dq0,
    input  logic             spi_dq1
);

    // state | meaning
    // IDLE  | S# high, accepting a request
    // CMD   | shifting the 8-bit command out on DQ0
    // ADDR  | shifting the 24-bit address out on DQ0
    // DUMMY | FAST_READ only: 8 clocks, DQ0 low, DQ1 ignored
    // DATA  | sampling DQ1, one byte per 8 clocks
    // DESEL | S# recovery before returning to IDLE
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DESEL = 3'd5;
`ifdef FAST_READ_EN
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CS_W  = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CS_W-1:0]  CS_LOAD  = CS_W'(CS_HIGH - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      out_q, out_d;
    logic [6:0]       in_q, in_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic             c_q, c_d;
    logic             s_n_q, s_n_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;
    logic             stall;

    // Hold C low before the first bit of a byte while the output register is still occupied.
    assign stall = (state_q == ST_DATA) && (bit_q == 5'd7) && !c_q && rd_valid_q && !rd_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        in_d        = in_q;
        div_d       = div_q;
        bit_d       = bit_q;
        len_d       = len_q;
        cs_d        = cs_q;
        c_d         = c_q;
        s_n_d       = s_n_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q & ~rd_ready;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = ST_CMD;
                    out_d       = {CMD_BYTE, req_addr};
                    len_d       = req_len;
                    bit_d       = 5'd7;
                    div_d       = DIV_LOAD;
                    c_d         = 1'b0;
                    s_n_d       = 1'b0;
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
                end
            end
            ST_DESEL: begin
                if (!s_n_q) begin
                    s_n_d = 1'b1;
                    cs_d  = CS_LOAD;
                end else if (cs_q == '0) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    cs_d = cs_q - CS_W'(1);
                end
            end
            default: begin
                if (!stall) begin
                    if (div_q != '0) begin
                        div_d = div_q - DIV_W'(1);
                    end else if (!c_q) begin
                        c_d   = 1'b1;
                        div_d = DIV_LOAD;
                    end else begin
                        // End of high phase: sample DQ1 and advance DQ0 on the same edge C falls.
                        c_d   = 1'b0;
                        div_d = DIV_LOAD;
                        out_d = {out_q[30:0], 1'b0};
                        bit_d = bit_q - 5'd1;
                        if (state_q == ST_DATA) begin
                            in_d = {in_q[5:0], spi_dq1};
                        end
                        if (bit_q == 5'd0) begin
                            if (state_q == ST_CMD) begin
                                state_d = ST_ADDR;
                                bit_d   = 5'd23;
                            end else if (state_q == ST_ADDR) begin
`ifdef FAST_READ_EN
                                state_d = ST_DUMMY;
`else
                                state_d = ST_DATA;
`endif
                                bit_d   = 5'd7;
`ifdef FAST_READ_EN
                            end else if (state_q == ST_DUMMY) begin
                                state_d = ST_DATA;
                                bit_d   = 5'd7;
`endif
                            end else begin
                                rd_data_d  = {in_q, spi_dq1};
                                rd_valid_d = 1'b1;
                                bit_d      = 5'd7;
                                if (len_q == '0) begin
                                    state_d = ST_DESEL;
                                end else begin
                                    len_d = len_q - LEN_W'(1);
                                end
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            in_q        <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            cs_q        <= '0;
            c_q         <= 1'b0;
            s_n_q       <= 1'b1;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            in_q        <= in_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            len_q       <= len_d;
            cs_q        <= cs_d;
            c_q         <= c_d;
            s_n_q       <= s_n_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign spi_c     = c_q;
    assign spi_s_n   = s_n_q;
    assign spi_dq0   = out_q[31];

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed bench for spi_flash_rd_ctrl with a small behavioural SPI-NOR read model on the pins.
`timescale 1ns/1ps
module tb_spi_flash_rd_ctrl;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 8;
    localparam int CS_HIGH = 4;
    localparam int TCLK    = 10;
`ifdef FAST_READ_EN
    localparam int         HDR_BITS = 40;
    localparam logic [7:0] CMD      = 8'h0B;
`else
    localparam int         HDR_BITS = 32;
    localparam logic [7:0] CMD      = 8'h03;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [23:0]      req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b1;
    logic             busy;
    logic             spi_c;
    logic             spi_s_n;
    logic             spi_dq0;
    logic             spi_dq1 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    spi_flash_rd_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_HIGH(CS_HIGH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
        .spi_c(spi_c), .spi_s_n(spi_s_n), .spi_dq0(spi_dq0), .spi_dq1(spi_dq1)
    );

    always #(TCLK/2) clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {a[22:16], 1'b0} ^ 8'h3C;
    endfunction

    // Flash model: capture header on C rising, drive DQ1 after C falling.
    bit          fl_active = 1'b0;
    int          fl_rise = 0;
    int          fl_k;
    logic [7:0]  fl_b;
    logic [31:0] fl_hdr = '0;
    logic [31:0] hdr_q[$];
    int          edges_q[$];
    time         last_rise = 0, min_per = 0, max_per = 0, sn_rise_t = 0;
    int          last_gap = 0;

    always @(negedge spi_s_n) begin
        fl_active = 1'b1;
        fl_rise   = 0;
        fl_hdr    = '0;
        last_gap  = int'(($time - sn_rise_t) / TCLK);
    end

    always @(posedge spi_s_n) begin
        sn_rise_t = $time;
        if (fl_active) begin
            hdr_q.push_back(fl_hdr);
            edges_q.push_back(fl_rise);
            fl_active = 1'b0;
        end
    end

    always @(posedge spi_c) begin
        if (fl_active) begin
            if (fl_rise > 0) begin
                if ($time - last_rise < min_per) min_per = $time - last_rise;
                if ($time - last_rise > max_per) max_per = $time - last_rise;
            end
            last_rise = $time;
            if (fl_rise < 32) fl_hdr = {fl_hdr[30:0], spi_dq0};
            fl_rise++;
        end
    end

    always @(negedge spi_c) begin
        if (fl_active && fl_rise >= HDR_BITS) begin
            fl_k    = fl_rise - HDR_BITS;
            fl_b    = mem_byte(fl_hdr[23:0] + 24'(fl_k / 8));
            spi_dq1 = fl_b[7 - (fl_k % 8)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] rx_q[$];
    int rv_cycles, bp_bad, bp_rise_delta, desel_hi;

    task automatic start_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
        int b = 0;
        @(negedge clk);
        while (!req_ready && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("req_ready_before_start", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 24'hA5A5A5;
        req_len   = '1;
    endtask

    task automatic collect(input int n, input int hold);
        int budget = 0, held_cnt = 0, r0 = 0;
        bit seen = 1'b0;
        logic [7:0] held = '0;
        rx_q.delete();
        rv_cycles = 0; bp_bad = 0; bp_rise_delta = -1;
        while (rx_q.size() < n && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (rd_valid) rv_cycles++;
            if (hold > 0 && !seen && rd_valid) begin
                seen = 1'b1; held = rd_data; r0 = fl_rise;
            end
            if (seen && held_cnt < hold) begin
                held_cnt++;
                if (spi_c || spi_s_n || !rd_valid || rd_data !== held) bp_bad++;
                if (held_cnt == hold) begin
                    rd_ready = 1'b1;
                    bp_rise_delta = fl_rise - r0;
                end
            end
            if (rd_valid && rd_ready) rx_q.push_back(rd_data);
        end
        chk("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int b = 0;
        desel_hi = 0;
        while (!(req_ready && !busy) && b < 2000) begin
            @(negedge clk);
            b++;
            if (spi_s_n && busy) desel_hi++;
        end
        chk("idle_reached", 32'(req_ready && !busy), 32'd1);
    endtask

    function automatic logic [31:0] last_hdr();
        return (hdr_q.size() > 0) ? hdr_q[hdr_q.size()-1] : 32'hDEADBEEF;
    endfunction

    function automatic int last_edges();
        return (edges_q.size() > 0) ? edges_q[edges_q.size()-1] : -1;
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_spi_c", 32'(spi_c), 32'd0);
        chk("rst_spi_s_n", 32'(spi_s_n), 32'd1);
        chk("rst_spi_dq0", 32'(spi_dq0), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single read, 0x123456 -> 0x7A
        hdr_q.delete(); edges_q.delete();
        min_per = 64'd1000000; max_per = 0;
        start_req(24'h123456, 8'd0);
        collect(1, 0);
        chk("single_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h7A);
        chk("single_rv_cycles", 32'(rv_cycles), 32'd1);
        wait_idle();
        chk("single_desel_ge", 32'(desel_hi >= CS_HIGH), 32'd1);
        chk("single_hdr", last_hdr(), {CMD, 24'h123456});
        chk("single_edges", 32'(last_edges()), 32'(HDR_BITS + 8));
        chk("single_min_per", 32'(min_per), 32'(2 * CLK_DIV * TCLK));
        chk("single_max_per", 32'(max_per), 32'(2 * CLK_DIV * TCLK));

        // Burst across a 256-byte boundary
        hdr_q.delete(); edges_q.delete();
        start_req(24'h0000FE, 8'd3);
        collect(4, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("burst_byte%0d", i), 32'((rx_q.size() > i) ? rx_q[i] : 8'h00),
                32'(mem_byte(24'h0000FE + 24'(i))));
        wait_idle();
        chk("burst_windows", 32'(hdr_q.size()), 32'd1);
        chk("burst_hdr", last_hdr(), {CMD, 24'h0000FE});
        chk("burst_edges", 32'(last_edges()), 32'(HDR_BITS + 32));

        // Backpressure: hold the first byte for 50 clocks
        hdr_q.delete(); edges_q.delete();
        rd_ready = 1'b0;
        start_req(24'h00ABC0, 8'd2);
        collect(3, 50);
        chk("bp_hold_bad", 32'(bp_bad), 32'd0);
        chk("bp_no_c_edges", 32'(bp_rise_delta), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_byte%0d", i), 32'((rx_q.size() > i) ? rx_q[i] : 8'h00),
                32'(mem_byte(24'h00ABC0 + 24'(i))));
        wait_idle();
        chk("bp_edges", 32'(last_edges()), 32'(HDR_BITS + 24));
        rd_ready = 1'b1;

        // Request held during busy
        hdr_q.delete(); edges_q.delete();
        start_req(24'h000200, 8'd1);
        repeat (20) @(negedge clk);
        req_valid = 1'b1; req_addr = 24'h000300; req_len = 8'd0;
        collect(2, 0);
        chk("busyreq_b0", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'(mem_byte(24'h000200)));
        chk("busyreq_b1", 32'((rx_q.size() > 1) ? rx_q[1] : 8'h00), 32'(mem_byte(24'h000201)));
        wait_idle();
        @(negedge clk);
        req_valid = 1'b0; req_addr = 24'h5A5A5A;
        collect(1, 0);
        chk("busyreq_second_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'(mem_byte(24'h000300)));
        wait_idle();
        chk("busyreq_windows", 32'(hdr_q.size()), 32'd2);
        chk("busyreq_first_hdr", (hdr_q.size() > 0) ? hdr_q[0] : 32'hDEADBEEF, {CMD, 24'h000200});
        chk("busyreq_first_edges", 32'((edges_q.size() > 0) ? edges_q[0] : -1), 32'(HDR_BITS + 16));
        chk("busyreq_second_hdr", last_hdr(), {CMD, 24'h000300});
        chk("busyreq_gap_ge", 32'(last_gap >= CS_HIGH), 32'd1);

        // Async reset in the address phase
        hdr_q.delete(); edges_q.delete();
        start_req(24'h0ABCDE, 8'd5);
        begin
            int b = 0;
            while (fl_rise < 12 && b < 1000) begin
                @(negedge clk);
                b++;
            end
        end
        chk("arst_in_addr", 32'(fl_rise >= 12 && fl_rise < 32), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_n", 32'(spi_s_n), 32'd1);
        chk("arst_c", 32'(spi_c), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_req(24'h000010, 8'd0);
        collect(1, 0);
        chk("arst_next_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'(mem_byte(24'h000010)));
        wait_idle();
        chk("arst_next_hdr", last_hdr(), {CMD, 24'h000010});
        chk("arst_next_edges", 32'(last_edges()), 32'(HDR_BITS + 8));

        // Read of 0x000100 (command and edge count follow the build option)
        hdr_q.delete(); edges_q.delete();
        start_req(24'h000100, 8'd0);
        collect(1, 0);
        chk("rd100_byte", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'(mem_byte(24'h000100)));
        wait_idle();
        chk("rd100_hdr", last_hdr(), {CMD, 24'h000100});
        chk("rd100_edges", 32'(last_edges()), 32'(HDR_BITS + 8));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
